// File: rtl/simt_branch_unit_if.sv
// simt_branch_unit bus: decoder/ALU inputs and warp PC/mask outputs.
// master drives the decode side, slave is the branch unit.
interface simt_branch_unit_if #(
   parameter int DATA_BITS   = 8,
   parameter int ADDR_BITS   = 8,
   parameter int THREADS     = 4,
   parameter int STACK_DEPTH = 4
);
   localparam int DW = $clog2(STACK_DEPTH + 1);

   logic                 enable;
   logic                 start;
   logic [THREADS-1:0]   start_mask;
   logic [2:0]           core_state;
   logic [2:0]           decoded_nzp;
   logic [ADDR_BITS-1:0] decoded_immediate;
   logic                 decoded_nzp_write_enable;
   logic                 decoded_pc_mux;
   logic                 decoded_sync;
   logic [DATA_BITS-1:0] alu_out [THREADS];
   logic [ADDR_BITS-1:0] warp_pc;
   logic [THREADS-1:0]   active_mask;
   logic [DW-1:0]        stack_depth;
   logic                 stack_overflow;

   modport master (
      output enable, start, start_mask, core_state,
      output decoded_nzp, decoded_immediate,
      output decoded_nzp_write_enable,
      output decoded_pc_mux, decoded_sync, alu_out,
      input  warp_pc, active_mask,
      input  stack_depth, stack_overflow
   );

   modport slave (
      input  enable, start, start_mask, core_state,
      input  decoded_nzp, decoded_immediate,
      input  decoded_nzp_write_enable,
      input  decoded_pc_mux, decoded_sync, alu_out,
      output warp_pc, active_mask,
      output stack_depth, stack_overflow
   );
endinterface

// File: rtl/simt_branch_unit.sv
// SIMT branch/PC unit: shared warp PC, active mask,
// per-thread NZP and a reconvergence stack.
module simt_branch_unit #(
   parameter int DATA_BITS   = 8,
   parameter int ADDR_BITS   = 8,
   parameter int THREADS     = 4,
   parameter int STACK_DEPTH = 4
) (
   input logic clk,
   input logic reset,
   simt_branch_unit_if.slave bus
);
   localparam int DW = $clog2(STACK_DEPTH + 1);
   localparam int IW =
      (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [ADDR_BITS-1:0] r_pc;
   logic [THREADS-1:0]   r_mask;
   logic [DW-1:0]        r_depth;
   logic                 r_ovf;
   logic [2:0]           r_nzp [THREADS];
   logic [THREADS-1:0]   r_pend_mask [STACK_DEPTH];
   logic [ADDR_BITS-1:0] r_pend_pc [STACK_DEPTH];
   logic [THREADS-1:0]   r_reconv [STACK_DEPTH];

   logic [THREADS-1:0]   w_taken;
   logic [IW-1:0]        w_top;
   logic [IW-1:0]        w_push_idx;
   logic                 w_empty;
   logic                 w_full;
   logic [ADDR_BITS-1:0] w_pc_inc;
   logic [ADDR_BITS-1:0] w_pc_nxt;
   logic [THREADS-1:0]   w_mask_nxt;
   logic [DW-1:0]        w_depth_nxt;
   logic                 w_ovf_nxt;
   logic                 w_push;
   logic                 w_clr_pend;
   logic                 w_pu;
   logic                 w_nzp_we;
   logic                 w_unused;

   // per-thread branch condition and unused ALU bits
   always_comb begin
      w_taken  = '0;
      w_unused = 1'b0;
      for (int i = 0; i < THREADS; i++) begin
         w_taken[i] = r_mask[i] &
            (|(r_nzp[i] & bus.decoded_nzp));
         w_unused = w_unused ^ (^bus.alu_out[i]);
      end
   end

   // stack pointers and state decode
   always_comb begin
      w_empty    = (r_depth == '0);
      w_full     = (r_depth == DW'(STACK_DEPTH));
      w_top      = w_empty ? '0 :
                   IW'(r_depth - DW'(1));
      w_push_idx = IW'(r_depth);
      w_pc_inc   = r_pc + ADDR_BITS'(1);
      w_pu       = bus.enable &&
                   (bus.core_state == 3'b101);
      w_nzp_we   = bus.enable &&
                   (bus.core_state == 3'b110) &&
                   bus.decoded_nzp_write_enable;
   end

   // PC-update next state: sync, branch or sequential
   always_comb begin
      w_pc_nxt    = r_pc;
      w_mask_nxt  = r_mask;
      w_depth_nxt = r_depth;
      w_ovf_nxt   = r_ovf;
      w_push      = 1'b0;
      w_clr_pend  = 1'b0;
      if (w_pu) begin
         if (bus.decoded_sync) begin
            if (w_empty) begin
               w_pc_nxt = w_pc_inc;
            end else if (r_pend_mask[w_top] != '0) begin
               w_mask_nxt = r_pend_mask[w_top];
               w_pc_nxt   = r_pend_pc[w_top];
               w_clr_pend = 1'b1;
            end else begin
               w_mask_nxt  = r_reconv[w_top];
               w_depth_nxt = r_depth - DW'(1);
               w_pc_nxt    = w_pc_inc;
            end
         end else if (bus.decoded_pc_mux) begin
            if (w_taken == r_mask) begin
               w_pc_nxt = bus.decoded_immediate;
            end else if (w_taken == '0) begin
               w_pc_nxt = w_pc_inc;
            end else begin
               w_mask_nxt = w_taken;
               w_pc_nxt   = bus.decoded_immediate;
               if (!w_full) begin
                  w_push      = 1'b1;
                  w_depth_nxt = r_depth + DW'(1);
               end else begin
                  w_ovf_nxt = 1'b1;
               end
            end
         end else begin
            w_pc_nxt = w_pc_inc;
         end
      end
   end

   // warp state, nzp and stack registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc    <= '0;
         r_mask  <= '0;
         r_depth <= '0;
         r_ovf   <= 1'b0;
         for (int i = 0; i < THREADS; i++)
            r_nzp[i] <= 3'b000;
         for (int s = 0; s < STACK_DEPTH; s++) begin
            r_pend_mask[s] <= '0;
            r_pend_pc[s]   <= '0;
            r_reconv[s]    <= '0;
         end
      end else if (bus.start) begin
         r_pc    <= '0;
         r_mask  <= bus.start_mask;
         r_depth <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_pc    <= w_pc_nxt;
         r_mask  <= w_mask_nxt;
         r_depth <= w_depth_nxt;
         r_ovf   <= w_ovf_nxt;
         if (w_nzp_we) begin
            for (int i = 0; i < THREADS; i++)
               if (r_mask[i])
                  r_nzp[i] <= bus.alu_out[i][2:0];
         end
         if (w_push) begin
            r_pend_mask[w_push_idx] <= r_mask & ~w_taken;
            r_pend_pc[w_push_idx]   <= w_pc_inc;
            r_reconv[w_push_idx]    <= r_mask;
         end
         if (w_clr_pend)
            r_pend_mask[w_top] <= '0;
      end
   end

   assign bus.warp_pc        = r_pc;
   assign bus.active_mask    = r_mask;
   assign bus.stack_depth    = r_depth;
   assign bus.stack_overflow = r_ovf;
endmodule

// File: tb/tb_simt_branch_unit.sv
// Bench for simt_branch_unit: two instances (stack 4 and 1)
// share one directed stimulus stream, checked against a stack model.
module tb_simt_branch_unit;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       s_reset = 1'b1;
   logic       s_enable = 1'b1;
   logic       s_start = 1'b0;
   logic [3:0] s_smask = 4'b0;
   logic [2:0] s_state = 3'b0;
   logic [2:0] s_nzp = 3'b0;
   logic [7:0] s_imm = 8'h0;
   logic       s_we = 1'b0;
   logic       s_pcm = 1'b0;
   logic       s_sync = 1'b0;
   logic [7:0] s_alu [4];

   simt_branch_unit_if #(.STACK_DEPTH(4)) if0 ();
   simt_branch_unit_if #(.STACK_DEPTH(1)) if1 ();

   assign if0.enable = s_enable;
   assign if0.start = s_start;
   assign if0.start_mask = s_smask;
   assign if0.core_state = s_state;
   assign if0.decoded_nzp = s_nzp;
   assign if0.decoded_immediate = s_imm;
   assign if0.decoded_nzp_write_enable = s_we;
   assign if0.decoded_pc_mux = s_pcm;
   assign if0.decoded_sync = s_sync;
   assign if0.alu_out = s_alu;
   assign if1.enable = s_enable;
   assign if1.start = s_start;
   assign if1.start_mask = s_smask;
   assign if1.core_state = s_state;
   assign if1.decoded_nzp = s_nzp;
   assign if1.decoded_immediate = s_imm;
   assign if1.decoded_nzp_write_enable = s_we;
   assign if1.decoded_pc_mux = s_pcm;
   assign if1.decoded_sync = s_sync;
   assign if1.alu_out = s_alu;

   simt_branch_unit #(.STACK_DEPTH(4)) dut0 (
      .clk(clk), .reset(s_reset), .bus(if0));
   simt_branch_unit #(.STACK_DEPTH(1)) dut1 (
      .clk(clk), .reset(s_reset), .bus(if1));

   typedef struct packed {
      logic [3:0] pend;
      logic [7:0] ppc;
      logic [3:0] rec;
   } st_t;

   logic [7:0] m_pc [2];
   logic [3:0] m_mask [2];
   int         m_dep [2];
   logic       m_ovf [2];
   logic [2:0] m_nzp [2][4];
   st_t        m_stk [2][4];

   int  n_vec = 0;
   int  n_mis = 0;
   bit  chk_on = 1'b0;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h @%0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic step(input int d, input int lim);
      logic [3:0] tk;
      tk = 4'b0;
      for (int i = 0; i < 4; i++)
         tk[i] = m_mask[d][i] && ((m_nzp[d][i] & s_nzp) != 0);
      if (s_reset) begin
         m_pc[d] = 0; m_mask[d] = 0; m_dep[d] = 0;
         m_ovf[d] = 0;
         for (int i = 0; i < 4; i++) m_nzp[d][i] = 0;
      end else if (s_start) begin
         m_pc[d] = 0; m_mask[d] = s_smask; m_dep[d] = 0;
         m_ovf[d] = 0;
      end else if (s_enable && s_state == 3'b110 && s_we) begin
         for (int i = 0; i < 4; i++)
            if (m_mask[d][i]) m_nzp[d][i] = s_alu[i][2:0];
      end else if (s_enable && s_state == 3'b101) begin
         if (s_sync) begin
            if (m_dep[d] == 0) begin
               m_pc[d]++;
            end else if (m_stk[d][m_dep[d]-1].pend != 0) begin
               m_mask[d] = m_stk[d][m_dep[d]-1].pend;
               m_pc[d] = m_stk[d][m_dep[d]-1].ppc;
               m_stk[d][m_dep[d]-1].pend = 0;
            end else begin
               m_mask[d] = m_stk[d][m_dep[d]-1].rec;
               m_dep[d]--;
               m_pc[d]++;
            end
         end else if (s_pcm) begin
            if (tk == m_mask[d]) m_pc[d] = s_imm;
            else if (tk == 0) m_pc[d]++;
            else begin
               if (m_dep[d] < lim) begin
                  m_stk[d][m_dep[d]] =
                     '{m_mask[d] & ~tk, m_pc[d] + 8'd1, m_mask[d]};
                  m_dep[d]++;
               end else m_ovf[d] = 1;
               m_mask[d] = tk;
               m_pc[d] = s_imm;
            end
         end else m_pc[d]++;
      end
   endtask

   // model advances on the same edge as the DUTs
   always @(posedge clk) begin
      step(0, 4);
      step(1, 1);
   end

   // compare both instances against the model every cycle
   always @(negedge clk) begin
      if (chk_on) begin
         chk("pc0", if0.warp_pc, m_pc[0]);
         chk("mask0", if0.active_mask, m_mask[0]);
         chk("dep0", if0.stack_depth, m_dep[0]);
         chk("ovf0", if0.stack_overflow, m_ovf[0]);
         chk("pc1", if1.warp_pc, m_pc[1]);
         chk("mask1", if1.active_mask, m_mask[1]);
         chk("dep1", if1.stack_depth, m_dep[1]);
         chk("ovf1", if1.stack_overflow, m_ovf[1]);
      end
   end

   task automatic op(input logic [2:0] st, input logic pcm,
                     input logic sy, input logic [2:0] nzp,
                     input logic [7:0] imm, input logic we);
      @(negedge clk);
      s_state = st; s_pcm = pcm; s_sync = sy;
      s_nzp = nzp; s_imm = imm; s_we = we;
      @(posedge clk);
      #1;
      s_state = 3'b0; s_pcm = 0; s_sync = 0; s_we = 0;
   endtask

   task automatic pcu();
      op(3'b101, 0, 0, 3'b0, 8'h0, 0);
   endtask
   task automatic br(input logic [2:0] n, input logic [7:0] a);
      op(3'b101, 1, 0, n, a, 0);
   endtask
   task automatic sync_i();
      op(3'b101, 0, 1, 3'b0, 8'h0, 0);
   endtask
   task automatic nzpw(input logic [7:0] a0, input logic [7:0] a1,
                       input logic [7:0] a2, input logic [7:0] a3);
      s_alu[0] = a0; s_alu[1] = a1; s_alu[2] = a2; s_alu[3] = a3;
      op(3'b110, 0, 0, 3'b0, 8'h0, 1);
   endtask
   task automatic strt(input logic [3:0] m);
      @(negedge clk);
      s_start = 1; s_smask = m;
      @(posedge clk);
      #1 s_start = 0;
   endtask
   task automatic rst();
      @(negedge clk);
      s_reset = 1;
      @(posedge clk);
      #1 s_reset = 0;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) s_alu[i] = 8'h0;
      rst();
      chk_on = 1'b1;
      chk("rst_pc", if0.warp_pc, 8'h00);
      chk("rst_mask", if0.active_mask, 4'b0000);
      chk("rst_dep", if0.stack_depth, 0);
      chk("rst_ovf", if0.stack_overflow, 0);

      strt(4'b1111);
      chk("start_mask", if0.active_mask, 4'b1111);
      chk("start_pc", if0.warp_pc, 8'h00);
      repeat (4) pcu();
      chk("seq_pc4", if0.warp_pc, 8'h04);

      nzpw(8'h02, 8'h02, 8'h02, 8'h02);
      pcu();
      br(3'b010, 8'h20);
      chk("brz_pc", if0.warp_pc, 8'h20);
      chk("brz_mask", if0.active_mask, 4'b1111);
      chk("brz_dep", if0.stack_depth, 0);
      strt(4'b1111);
      repeat (5) pcu();
      br(3'b100, 8'h20);
      chk("brn_pc", if0.warp_pc, 8'h06);

      strt(4'b1111);
      nzpw(8'h02, 8'h02, 8'h01, 8'h01);
      repeat (5) pcu();
      br(3'b010, 8'h20);
      chk("div_mask", if0.active_mask, 4'b0011);
      chk("div_pc", if0.warp_pc, 8'h20);
      chk("div_dep", if0.stack_depth, 1);
      sync_i();
      chk("sync1_mask", if0.active_mask, 4'b1100);
      chk("sync1_pc", if0.warp_pc, 8'h06);
      sync_i();
      chk("sync2_mask", if0.active_mask, 4'b1111);
      chk("sync2_dep", if0.stack_depth, 0);
      chk("sync2_pc", if0.warp_pc, 8'h07);

      strt(4'b1111);
      br(3'b010, 8'h10);
      nzpw(8'h04, 8'h04, 8'h04, 8'h04);
      br(3'b100, 8'h30);
      chk("nzp_act_pc", if0.warp_pc, 8'h30);
      sync_i();
      chk("nzp_sw_mask", if0.active_mask, 4'b1100);
      br(3'b100, 8'h40);
      chk("nzp_keep_pc", if0.warp_pc, 8'h02);
      sync_i();
      br(3'b001, 8'h50);
      chk("brp_mask", if0.active_mask, 4'b1100);

      nzpw(8'h01, 8'h01, 8'h02, 8'h01);
      br(3'b010, 8'h60);
      chk("nest_dep0", if0.stack_depth, 2);
      chk("nest_ovf0", if0.stack_overflow, 0);
      chk("ovf1", if1.stack_overflow, 1);
      chk("ovf_dep1", if1.stack_depth, 1);
      chk("ovf_mask1", if1.active_mask, 4'b0100);
      strt(4'b1111);
      chk("start_clr_ovf", if1.stack_overflow, 0);
      sync_i();
      chk("sync_empty_pc", if1.warp_pc, 8'h01);
      chk("sync_empty_mask", if1.active_mask, 4'b1111);

      br(3'b100, 8'h10);
      nzpw(8'h02, 8'h01, 8'h00, 8'h00);
      br(3'b010, 8'h20);
      chk("nest2_dep0", if0.stack_depth, 2);
      br(3'b010, 8'hFF);
      chk("pc_ff", if0.warp_pc, 8'hFF);
      pcu();
      chk("pc_wrap", if0.warp_pc, 8'h00);
      s_enable = 0;
      pcu();
      s_enable = 1;
      chk("en_hold", if0.warp_pc, 8'h00);
      op(3'b000, 1, 0, 3'b010, 8'h44, 0);
      chk("state_hold", if0.warp_pc, 8'h00);

      rst();
      chk("rst2_pc", if0.warp_pc, 8'h00);
      chk("rst2_mask", if0.active_mask, 4'b0000);
      chk("rst2_dep", if0.stack_depth, 0);
      chk("rst2_ovf", if1.stack_overflow, 0);

      strt(4'b0000);
      br(3'b010, 8'h33);
      chk("empty_pc", if0.warp_pc, 8'h33);
      chk("empty_dep", if0.stack_depth, 0);

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_mis);
      $finish;
   end
endmodule

// File: doc/simt_branch_unit.md
Name: simt_branch_unit

Overview:
- Per-block SIMT branch/PC unit: one shared warp PC, a per-thread active mask, and a reconvergence stack.
- It generalises the per-thread PC/NZP unit so that divergent BRnzp branches serialise the taken and not-taken paths.
- A SYNC instruction reconverges the paths.
- Sits in each core between the decoder/ALUs and the fetcher; the fetcher reads warp_pc, and the LSU/ALUs/register files gate per-thread writes with active_mask.

Parameters:
- DATA_BITS, 8, ALU result width.
- ADDR_BITS, 8, program memory address width.
- THREADS, 4, threads per block (mask width).
- STACK_DEPTH, 4, reconvergence stack entries (≥1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  block active; when low, all state holds except reset/start.
- start  in  1  one-cycle launch pulse.
- start_mask  in  THREADS  threads present in the launched block.
- core_state  in  3  core FSM state; 3'b101 = PC-update, 3'b110 = NZP-write.
- decoded_nzp  in  3  branch condition {n,z,p}.
- decoded_immediate  in  ADDR_BITS  branch target.
- decoded_nzp_write_enable  in  1  CMP result to be captured.
- decoded_pc_mux  in  1  current instruction is BRnzp.
- decoded_sync  in  1  current instruction is SYNC.
- alu_out  in  THREADS×DATA_BITS  per-thread ALU results, unpacked array; bits [2:0] = {n,z,p}.
- warp_pc  out  ADDR_BITS  PC of the next instruction.
- active_mask  out  THREADS  threads executing the current path.
- stack_depth  out  clog2(STACK_DEPTH+1)  occupied entries.
- stack_overflow  out  1  sticky error flag.

Behaviour:
- Reset values: warp_pc=0, active_mask=0, stack_depth=0, stack_overflow=0, all nzp[i]=3'b000, all stack entries cleared.
- Priority each cycle: reset > start > (enable && core_state actions).
- start: warp_pc←0, active_mask←start_mask, stack_depth←0, stack_overflow←0; nzp unchanged.
- Stack entry fields: {pend_mask[THREADS], pend_pc[ADDR_BITS], reconv_mask[THREADS]}. Top = entry stack_depth-1.
- NZP-write (core_state==3'b110, decoded_nzp_write_enable=1): nzp[i]←alu_out[i][2:0] only for threads with active_mask[i]=1; inactive threads keep their value.
- PC-update (core_state==3'b101), single-cycle, registered outputs valid the next cycle.
- Branch evaluation: taken[i] = active_mask[i] & |(nzp[i] & decoded_nzp).
- Case sync (decoded_sync=1; takes priority over decoded_pc_mux, and both high is illegal but defined this way):
  - stack empty: warp_pc←warp_pc+1; no other change.
  - top.pend_mask≠0: active_mask←top.pend_mask; warp_pc←top.pend_pc; top.pend_mask←0.
  - top.pend_mask==0: pop; active_mask←top.reconv_mask; stack_depth−1; warp_pc←warp_pc+1.
- Case branch (decoded_pc_mux=1, not sync):
  - taken==active_mask: uniform taken; warp_pc←decoded_immediate.
  - taken==0: uniform fall-through; warp_pc←warp_pc+1.
  - otherwise divergent, stack not full: push {active_mask&~taken, warp_pc+1, active_mask}; active_mask←taken; warp_pc←decoded_immediate.
  - otherwise divergent, stack full (depth==STACK_DEPTH): no push; stack_overflow←1 (sticky until reset/start); active_mask←taken; warp_pc←decoded_immediate; not-taken threads are dropped.
- Case other instruction: warp_pc←warp_pc+1.
- PC arithmetic is modulo 2^ADDR_BITS: warp_pc=all-ones+1 wraps to 0, with no flag.
- core_state values other than 3'b101/3'b110, or enable=0: no state change.
- active_mask==0 (empty launch): branches evaluate taken==0==active_mask, so the uniform-taken path wins; behaviour stays defined and no push occurs.
- Reset or start mid-divergence discards the whole stack immediately.

Test Plan:
- reset, start with start_mask=4'b1111 → warp_pc=0, active_mask=1111, depth=0; four non-branch PC-updates → warp_pc=4.
- All threads nzp=3'b010, BRz to 0x20 at pc=5 → warp_pc=0x20, active_mask unchanged, depth=0; BRn instead → warp_pc=6.
- Threads 0,1 nzp=010 and threads 2,3 nzp=001, BRz to 0x20 at pc=5 → active=0011, pc=0x20, depth=1. First SYNC → active=1100, pc=6. Second SYNC → active=1111, depth=0, pc=7.
- NZP-write with active_mask=0011 and alu_out low bits 100 for all threads → nzp[0..1]=100, nzp[2..3] keep their prior value.
- STACK_DEPTH=1: two nested divergent branches → the second sets stack_overflow=1 with depth staying 1; start clears the flag; SYNC on an empty stack → pc+1 only.
- warp_pc=0xFF with a non-branch → 0x00; reset asserted while depth=2 → all outputs at reset values the next cycle.
